// File: rtl/sram_march_bist.sv
// March C- BIST engine that drives a single-port SRAM with one-cycle read latency and records the first failure.
// Defining SRAM_BIST_FAIL_COUNT_EN adds a saturating 16-bit fail_count output.
module sram_march_bist #(
    parameter int ADDR_WIDTH  = 12,
    parameter int DATA_WIDTH  = 8,
    parameter int WMASK_WIDTH = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic                   fail,
    output logic [ADDR_WIDTH-1:0]  fail_addr,
    output logic [DATA_WIDTH-1:0]  fail_data,
    output logic [2:0]             fail_element,
`ifdef SRAM_BIST_FAIL_COUNT_EN
    output logic [15:0]            fail_count,
`endif
    output logic                   sram_we,
    output logic [WMASK_WIDTH-1:0] sram_wmask,
    output logic [ADDR_WIDTH-1:0]  sram_addr,
    output logic [DATA_WIDTH-1:0]  sram_din,
    input  logic [DATA_WIDTH-1:0]  sram_dout
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = {ADDR_WIDTH{1'b1}};

    state_t                 state_q;
    logic [2:0]             elem_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic                   op_q;
    logic                   end_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   fail_q;
    logic [ADDR_WIDTH-1:0]  fail_addr_q;
    logic [DATA_WIDTH-1:0]  fail_data_q;
    logic [2:0]             fail_elem_q;
    logic                   sram_we_q;
    logic [WMASK_WIDTH-1:0] sram_wmask_q;
    logic [ADDR_WIDTH-1:0]  sram_addr_q;
    logic [DATA_WIDTH-1:0]  sram_din_q;
    logic                   rd0_q;
    logic [DATA_WIDTH-1:0]  exp0_q;
    logic [2:0]             elem0_q;
    logic                   pend_q;
    logic [DATA_WIDTH-1:0]  pend_exp_q;
    logic [2:0]             pend_elem_q;
    logic [ADDR_WIDTH-1:0]  pend_addr_q;
`ifdef SRAM_BIST_FAIL_COUNT_EN
    logic [15:0]            fail_count_q;
`endif

    logic                   is_read;
    logic                   write_one;
    logic                   read_one;
    logic                   last_op;
    logic                   descending;
    logic                   last_addr;
    logic                   final_op;
    logic                   accept;
    logic                   issue;
    logic                   mismatch;
    logic [2:0]             elem_d;
    logic [ADDR_WIDTH-1:0]  addr_d;
    logic                   op_d;

    // Decode the op pointed to by (elem_q, addr_q, op_q) and compute the pointer to the following op.
    always_comb begin
        is_read    = (elem_q == 3'd5) || ((elem_q != 3'd0) && !op_q);
        write_one  = (elem_q == 3'd1) || (elem_q == 3'd3);
        read_one   = (elem_q == 3'd2) || (elem_q == 3'd4);
        last_op    = (elem_q == 3'd0) || (elem_q == 3'd5) || op_q;
        descending = (elem_q == 3'd3) || (elem_q == 3'd4);
        last_addr  = descending ? (addr_q == '0) : (addr_q == ADDR_MAX);
        final_op   = last_op && last_addr && (elem_q == 3'd5);
        accept     = ((state_q == IDLE) || (state_q == DONE)) && start;
        issue      = accept || ((state_q == RUN) && !end_q);
        mismatch   = pend_q && (sram_dout != pend_exp_q);

        elem_d = elem_q;
        addr_d = addr_q;
        op_d   = op_q;
        if (!last_op) begin
            op_d = 1'b1;
        end else begin
            op_d = 1'b0;
            if (final_op) begin
                elem_d = 3'd0;
                addr_d = '0;
            end else if (last_addr) begin
                elem_d = elem_q + 3'd1;
                // Elements 3 and 4 walk downwards, so entering them starts from the top address.
                addr_d = ((elem_q == 3'd2) || (elem_q == 3'd3)) ? ADDR_MAX : '0;
            end else begin
                addr_d = descending ? (addr_q - ADDR_WIDTH'(1)) : (addr_q + ADDR_WIDTH'(1));
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            elem_q       <= 3'd0;
            addr_q       <= '0;
            op_q         <= 1'b0;
            end_q        <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            fail_q       <= 1'b0;
            fail_addr_q  <= '0;
            fail_data_q  <= '0;
            fail_elem_q  <= 3'd0;
            sram_we_q    <= 1'b0;
            sram_wmask_q <= '0;
            sram_addr_q  <= '0;
            sram_din_q   <= '0;
            rd0_q        <= 1'b0;
            exp0_q       <= '0;
            elem0_q      <= 3'd0;
            pend_q       <= 1'b0;
            pend_exp_q   <= '0;
            pend_elem_q  <= 3'd0;
            pend_addr_q  <= '0;
`ifdef SRAM_BIST_FAIL_COUNT_EN
            fail_count_q <= 16'd0;
`endif
        end else begin
            // The SRAM performs the read one edge after the op is driven; dout is checked one edge later.
            pend_q      <= rd0_q;
            pend_exp_q  <= exp0_q;
            pend_elem_q <= elem0_q;
            pend_addr_q <= sram_addr_q;

            if (mismatch) begin
                fail_q <= 1'b1;
                if (!fail_q) begin
                    fail_addr_q <= pend_addr_q;
                    fail_data_q <= sram_dout;
                    fail_elem_q <= pend_elem_q;
                end
`ifdef SRAM_BIST_FAIL_COUNT_EN
                if (fail_count_q != 16'hFFFF) begin
                    fail_count_q <= fail_count_q + 16'd1;
                end
`endif
            end

            sram_we_q    <= 1'b0;
            sram_wmask_q <= '0;
            sram_addr_q  <= '0;
            sram_din_q   <= '0;
            rd0_q        <= 1'b0;

            if (issue) begin
                sram_we_q    <= !is_read;
                sram_wmask_q <= is_read ? '0 : {WMASK_WIDTH{1'b1}};
                sram_addr_q  <= addr_q;
                sram_din_q   <= is_read ? '0 : {DATA_WIDTH{write_one}};
                rd0_q        <= is_read;
                exp0_q       <= {DATA_WIDTH{read_one}};
                elem0_q      <= elem_q;
                elem_q       <= elem_d;
                addr_q       <= addr_d;
                op_q         <= op_d;
                end_q        <= final_op;
            end

            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q     <= RUN;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        fail_q      <= 1'b0;
                        fail_addr_q <= '0;
                        fail_data_q <= '0;
                        fail_elem_q <= 3'd0;
`ifdef SRAM_BIST_FAIL_COUNT_EN
                        fail_count_q <= 16'd0;
`endif
                    end
                end
                RUN: begin
                    if (end_q) begin
                        state_q <= DRAIN;
                        end_q   <= 1'b0;
                    end
                end
                DRAIN: begin
                    state_q <= DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign fail         = fail_q;
    assign fail_addr    = fail_addr_q;
    assign fail_data    = fail_data_q;
    assign fail_element = fail_elem_q;
    assign sram_we      = sram_we_q;
    assign sram_wmask   = sram_wmask_q;
    assign sram_addr    = sram_addr_q;
    assign sram_din     = sram_din_q;
`ifdef SRAM_BIST_FAIL_COUNT_EN
    assign fail_count   = fail_count_q;
`endif

endmodule

// File: tb/tb_sram_march_bist.sv
// Bench for sram_march_bist: behavioural SRAM with injectable faults plus a March C- reference walk.
// Optional fail_count checks follow SRAM_BIST_FAIL_COUNT_EN.
module tb_sram_march_bist;

    localparam int AW    = 10;
    localparam int DW    = 8;
    localparam int WMW   = 1;
    localparam int DEPTH = 1 << AW;
    localparam int NOPS  = 10 * DEPTH;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           start = 1'b0;
    logic           busy, done, fail;
    logic [AW-1:0]  fail_addr;
    logic [DW-1:0]  fail_data;
    logic [2:0]     fail_element;
    logic           sram_we;
    logic [WMW-1:0] sram_wmask;
    logic [AW-1:0]  sram_addr;
    logic [DW-1:0]  sram_din;
    logic [DW-1:0]  sram_dout;
`ifdef SRAM_BIST_FAIL_COUNT_EN
    logic [15:0]    fail_count;
`endif

    sram_march_bist #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WMASK_WIDTH(WMW)) dut (
        .clk(clk), .rst(rst), .start(start),
        .busy(busy), .done(done), .fail(fail),
        .fail_addr(fail_addr), .fail_data(fail_data), .fail_element(fail_element),
`ifdef SRAM_BIST_FAIL_COUNT_EN
        .fail_count(fail_count),
`endif
        .sram_we(sram_we), .sram_wmask(sram_wmask), .sram_addr(sram_addr),
        .sram_din(sram_din), .sram_dout(sram_dout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // 0 none, 1 bit3 stuck-at-1 @0x123, 2 bit3 stuck-at-0 @0x123, 3 write-ones @0x200 sets bit0 @0x1FF, 4 all reads inverted
    int fault_mode = 0;

    bit [DW-1:0] mem [DEPTH];
    bit [DW-1:0] ref_mem [DEPTH];

    logic          exp_we   [NOPS];
    logic [AW-1:0] exp_addr [NOPS];
    logic [DW-1:0] exp_din  [NOPS];

    string march_ops [6] = '{"w0", "r0w1", "r1w0", "r0w1", "r1w0", "r0"};
    string march_dir = "UUUDDU";

    function automatic logic [DW-1:0] faulty_read(input logic [DW-1:0] v, input int a);
        logic [DW-1:0] r;
        r = v;
        if (fault_mode == 1 && a == 32'h123) r = v | DW'(8);
        if (fault_mode == 2 && a == 32'h123) r = v & ~DW'(8);
        if (fault_mode == 4) r = ~v;
        return r;
    endfunction

    always @(posedge clk) begin
        if (sram_we) begin
            mem[sram_addr] <= sram_din;
            if (fault_mode == 3 && int'(sram_addr) == 32'h200 && sram_din == '1)
                mem[32'h1FF] <= mem[32'h1FF] | DW'(1);
        end else begin
            sram_dout <= faulty_read(mem[sram_addr], int'(sram_addr));
        end
    end

    // Walks March C- over ref_mem: fills the expected op stream and the expected failure record.
    task automatic walk_march(output bit rf, output int ra, output int rd, output int re, output int rc);
        int k, a;
        bit is_w;
        logic [DW-1:0] val, got;
        k = 0; rf = 0; ra = 0; rd = 0; re = 0; rc = 0;
        for (int e = 0; e < 6; e++) begin
            for (int i = 0; i < DEPTH; i++) begin
                a = (march_dir.getc(e) == "D") ? DEPTH - 1 - i : i;
                for (int o = 0; o < march_ops[e].len(); o += 2) begin
                    is_w = (march_ops[e].getc(o) == "w");
                    val  = (march_ops[e].getc(o + 1) == "1") ? '1 : '0;
                    exp_we[k]   = is_w;
                    exp_addr[k] = AW'(a);
                    exp_din[k]  = is_w ? val : '0;
                    k++;
                    if (is_w) begin
                        ref_mem[a] = val;
                        if (fault_mode == 3 && a == 32'h200 && val == '1)
                            ref_mem[32'h1FF] = ref_mem[32'h1FF] | DW'(1);
                    end else begin
                        got = faulty_read(ref_mem[a], a);
                        if (got != val) begin
                            if (!rf) begin rf = 1; ra = a; rd = int'(got); re = e; end
                            rc++;
                        end
                    end
                end
            end
        end
    endtask

    // Starts a run and checks every driven op, the drain cycle and the final status against the reference.
    task automatic run_march(input string name, input bit noise);
        bit rf; int ra, rd, re, rc;
        int noise_k, seq_err;
        walk_march(rf, ra, rd, re, rc);
        noise_k = noise ? int'($urandom_range(NOPS - 3, 1)) : -1;
        seq_err = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        checks++;
        if ({busy, done, fail} !== 3'b100) begin
            failures++;
            $display("FAIL %s start_clear: busy/done/fail=%b required 100", name, {busy, done, fail});
        end
        for (int k = 0; k < NOPS; k++) begin
            if (k > 0) @(negedge clk);
            start = (k == noise_k);
            checks++;
            if ({sram_we, sram_wmask, sram_addr, sram_din, busy} !==
                {exp_we[k], {WMW{exp_we[k]}}, exp_addr[k], exp_din[k], 1'b1}) begin
                failures++;
                seq_err++;
                if (seq_err <= 8)
                    $display("FAIL %s op%0d: we=%b wm=%b addr=%h din=%h busy=%b required we=%b addr=%h din=%h busy=1",
                             name, k, sram_we, sram_wmask, sram_addr, sram_din, busy,
                             exp_we[k], exp_addr[k], exp_din[k]);
            end
        end
        @(negedge clk);
        start = 1'b0;
        checks++;
        if ({busy, done, sram_we, sram_wmask, sram_addr, sram_din} !== {1'b1, 1'b0, 1'b0, {WMW{1'b0}}, {AW{1'b0}}, {DW{1'b0}}}) begin
            failures++;
            $display("FAIL %s drain: busy=%b done=%b we=%b addr=%h din=%h required busy=1 done=0 idle port",
                     name, busy, done, sram_we, sram_addr, sram_din);
        end
        if (noise) start = 1'b1;   // high while DRAIN is sampled: must be ignored
        @(negedge clk);
        start = 1'b0;
        checks++;
        if ({busy, done} !== 2'b01) begin
            failures++;
            $display("FAIL %s done: busy=%b done=%b required busy=0 done=1", name, busy, done);
        end
        checks++;
        if (fail !== rf) begin
            failures++;
            $display("FAIL %s fail_flag: got %b required %b", name, fail, rf);
        end
        checks++;
        if ({fail_addr, fail_data, fail_element} !== {AW'(ra), DW'(rd), 3'(re)}) begin
            failures++;
            $display("FAIL %s capture: addr=%h data=%h elem=%0d required addr=%h data=%h elem=%0d",
                     name, fail_addr, fail_data, fail_element, ra, rd, re);
        end
`ifdef SRAM_BIST_FAIL_COUNT_EN
        checks++;
        if (fail_count !== 16'(rc)) begin
            failures++;
            $display("FAIL %s fail_count: got %0d required %0d", name, fail_count, rc);
        end
`endif
        $display("run %s: ops=%0d fail=%b addr=%h data=%h elem=%0d ref_mismatches=%0d",
                 name, NOPS, fail, fail_addr, fail_data, fail_element, rc);
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #12;
        checks++;
        if ({busy, done, fail, fail_addr, fail_data, fail_element, sram_we, sram_wmask, sram_addr, sram_din} !== '0) begin
            failures++;
            $display("FAIL reset_values: busy=%b done=%b fail=%b we=%b addr=%h din=%h required all zero",
                     busy, done, fail, sram_we, sram_addr, sram_din);
        end
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done, sram_we} !== 3'b000) begin
            failures++;
            $display("FAIL reset_idle: busy/done/we=%b required 000", {busy, done, sram_we});
        end
        $display("test_reset: busy=%b done=%b fail=%b", busy, done, fail);
    endtask

    task automatic test_fault_free();
        fault_mode = 0;
        run_march("fault_free", 1'b1);
    endtask

    task automatic test_stuck_at_1();
        fault_mode = 1;
        run_march("stuck_at_1", 1'b0);
    endtask

    task automatic test_stuck_at_0();
        fault_mode = 2;
        run_march("stuck_at_0", 1'b0);
    endtask

    task automatic test_reset_mid_run();
        int r;
        bit found;
        fault_mode = 4;   // every read mismatches, so a surviving stale compare would raise fail
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        r = int'($urandom_range(6 * DEPTH, 4 * DEPTH));
        repeat (r) @(negedge clk);
        found = 0;
        for (int i = 0; i < 4 && !found; i++) begin
            if (sram_we === 1'b0 && busy === 1'b1) found = 1;
            else @(negedge clk);
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL mid_run_read: no read in flight within 4 cycles, we=%b busy=%b", sram_we, busy);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, fail, fail_addr, fail_data, fail_element, sram_we, sram_wmask, sram_addr, sram_din} !== '0) begin
            failures++;
            $display("FAIL mid_run_reset: busy=%b done=%b fail=%b we=%b addr=%h din=%h required all zero",
                     busy, done, fail, sram_we, sram_addr, sram_din);
        end
        @(negedge clk); rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, fail, sram_we} !== 4'b0000) begin
            failures++;
            $display("FAIL post_reset_idle: busy/done/fail/we=%b required 0000", {busy, done, fail, sram_we});
        end
        $display("test_reset_mid_run: reset after %0d cycles, busy=%b fail=%b", r, busy, fail);
    endtask

    task automatic test_coupling();
        fault_mode = 3;
        run_march("coupling", 1'b0);
    endtask

    initial begin
        test_reset();
        test_fault_free();
        test_stuck_at_1();
        test_stuck_at_0();
        test_reset_mid_run();
        test_coupling();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
